// File: rtl/rvc_inst_aligner.sv
`default_nettype none
// ============================================================================
// Module   : rvc_inst_aligner
// Purpose  : Halfword realignment buffer between fetch and the RVC decoder.
//            Splits word-aligned fetch packets into 16-bit parcels and
//            presents one 16- or 32-bit instruction per cycle with its PC.
// Revision : 1.0 - initial release
// ============================================================================
module rvc_inst_aligner #(
  parameter int unsigned VADDR_WIDTH = 39
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic [VADDR_WIDTH-1:0] flush_pc_i,
  input  logic                   fetch_valid_i,
  output logic                   fetch_ready_o,
  input  logic [31:0]            fetch_data_i,
  input  logic [VADDR_WIDTH-1:0] fetch_pc_i,
  output logic                   inst_valid_o,
  input  logic                   inst_ready_i,
  output logic [31:0]            inst_o,
  output logic                   is_rv_o,
  output logic [VADDR_WIDTH-1:0] inst_pc_o
);

  // Parcel buffer, hw_q[0] is the oldest parcel (lowest address).
  logic [15:0]            hw_q [3];
  logic [15:0]            hw_d [3];
  logic [15:0]            hw_sh [3];
  logic [1:0]             count_q, count_d;
  logic [VADDR_WIDTH-1:0] head_pc_q, head_pc_d;
  logic                   skip_lo_q, skip_lo_d;

  logic       pop, push;
  logic [1:0] pop_n, push_n, rem;
  logic [15:0] par_a, par_b;

  // Head decode and handshakes; fetch_ready depends only on registered count.
  always_comb begin
    is_rv_o       = (count_q != 2'd0) && (hw_q[0][1:0] == 2'b11);
    inst_valid_o  = !flush_i && (count_q != 2'd0) && (!is_rv_o || count_q >= 2'd2);
    inst_o        = is_rv_o ? {hw_q[1], hw_q[0]} : {16'h0000, hw_q[0]};
    inst_pc_o     = head_pc_q;
    fetch_ready_o = (count_q <= 2'd1);
    pop           = inst_valid_o && inst_ready_i;
    push          = fetch_valid_i && fetch_ready_o && !flush_i;
    pop_n         = pop ? (is_rv_o ? 2'd2 : 2'd1) : 2'd0;
    push_n        = push ? (skip_lo_q ? 2'd1 : 2'd2) : 2'd0;
    rem           = count_q - pop_n;
    // After a redirect into the upper halfword only [31:16] is kept.
    par_a         = skip_lo_q ? fetch_data_i[31:16] : fetch_data_i[15:0];
    par_b         = fetch_data_i[31:16];
  end

  // Next state: pop shifts the buffer down, push appends after the survivors.
  always_comb begin
    hw_sh = hw_q;
    unique case (pop_n)
      2'd1: begin
        hw_sh[0] = hw_q[1];
        hw_sh[1] = hw_q[2];
      end
      2'd2: begin
        hw_sh[0] = hw_q[2];
      end
      default: ;
    endcase

    hw_d = hw_sh;
    if (push) begin
      for (int i = 0; i < 3; i++) begin
        if (rem == 2'(i)) begin
          hw_d[i] = par_a;
        end else if (!skip_lo_q && (rem + 2'd1) == 2'(i)) begin
          hw_d[i] = par_b;
        end
      end
    end

    count_d   = rem + push_n;
    skip_lo_d = push ? 1'b0 : skip_lo_q;

    head_pc_d = head_pc_q;
    if (pop) begin
      head_pc_d = head_pc_q + (is_rv_o ? VADDR_WIDTH'(4) : VADDR_WIDTH'(2));
    end
    // An empty buffer takes its PC from the incoming packet.
    if (push && rem == 2'd0) begin
      head_pc_d = fetch_pc_i + (skip_lo_q ? VADDR_WIDTH'(2) : VADDR_WIDTH'(0));
    end

    // Redirect discards everything; handshakes were already masked above.
    if (flush_i) begin
      count_d   = 2'd0;
      skip_lo_d = flush_pc_i[1];
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= 2'd0;
      skip_lo_q <= 1'b0;
      head_pc_q <= '0;
      for (int i = 0; i < 3; i++) begin
        hw_q[i] <= 16'h0000;
      end
    end else begin
      count_q   <= count_d;
      skip_lo_q <= skip_lo_d;
      head_pc_q <= head_pc_d;
      for (int i = 0; i < 3; i++) begin
        hw_q[i] <= hw_d[i];
      end
    end
  end

endmodule
`default_nettype wire
